// File: rtl/pkg_display.sv
// Shared 7-segment display definitions.
// Holds the active-high glyph constants (bit order gfedcba) and the nibble
// to glyph lookup, so that any display block renders digits the same way.
package pkg_display;

  localparam logic [6:0] GLIFO_0      = 7'h3F;
  localparam logic [6:0] GLIFO_1      = 7'h06;
  localparam logic [6:0] GLIFO_2      = 7'h5B;
  localparam logic [6:0] GLIFO_3      = 7'h4F;
  localparam logic [6:0] GLIFO_4      = 7'h66;
  localparam logic [6:0] GLIFO_5      = 7'h6D;
  localparam logic [6:0] GLIFO_6      = 7'h7D;
  localparam logic [6:0] GLIFO_7      = 7'h07;
  localparam logic [6:0] GLIFO_8      = 7'h7F;
  localparam logic [6:0] GLIFO_9      = 7'h6F;
  localparam logic [6:0] GLIFO_A      = 7'h77;
  localparam logic [6:0] GLIFO_B      = 7'h7C;
  localparam logic [6:0] GLIFO_C      = 7'h39;
  localparam logic [6:0] GLIFO_D      = 7'h5E;
  localparam logic [6:0] GLIFO_E      = 7'h79;
  localparam logic [6:0] GLIFO_F      = 7'h71;
  localparam logic [6:0] GLIFO_BLANCO = 7'h00;

  // Codes 10-15 render blank unless hex glyphs are requested.
  function automatic logic [6:0] glifo(input logic [3:0] nibble, input bit hex);
    logic [6:0] g;
    unique case (nibble)
      4'h0:    g = GLIFO_0;
      4'h1:    g = GLIFO_1;
      4'h2:    g = GLIFO_2;
      4'h3:    g = GLIFO_3;
      4'h4:    g = GLIFO_4;
      4'h5:    g = GLIFO_5;
      4'h6:    g = GLIFO_6;
      4'h7:    g = GLIFO_7;
      4'h8:    g = GLIFO_8;
      4'h9:    g = GLIFO_9;
      4'hA:    g = hex ? GLIFO_A : GLIFO_BLANCO;
      4'hB:    g = hex ? GLIFO_B : GLIFO_BLANCO;
      4'hC:    g = hex ? GLIFO_C : GLIFO_BLANCO;
      4'hD:    g = hex ? GLIFO_D : GLIFO_BLANCO;
      4'hE:    g = hex ? GLIFO_E : GLIFO_BLANCO;
      default: g = hex ? GLIFO_F : GLIFO_BLANCO;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/controlador_display_7seg_decodificador_glifo.sv
// Combinational nibble to 7-segment glyph decoder.
// Ports:
//   nibble_i  4-bit digit code
//   patron_o  active-high segment pattern, [0]=a .. [6]=g
module decodificador_glifo
  import pkg_display::*;
#(
  parameter bit MODO_HEX = 1'b0
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] patron_o
);

  assign patron_o = glifo(nibble_i, MODO_HEX);

endmodule

// File: rtl/controlador_display_7seg.sv
// Multiplexed N-digit 7-segment display driver.
// Scans one digit per refresh slot, blanks the anodes for the first
// BLANK_CICLOS of each slot to avoid ghosting, and renders from a snapshot of
// the inputs taken only at frame wrap so a frame never mixes two values.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   habilitar      scan enable; low freezes scanning and turns anodes off
//   digitos        packed nibbles, [3:0] = digit 0 (units)
//   punto          decimal point request per digit
//   supr_ceros     leading-zero suppression enable
//   segmentos      {dp,g..a} at pin polarity
//   anodos         one-hot digit select at pin polarity
//   digito_actual  index of the digit being shown
//   fin_barrido    one-cycle pulse at each frame wrap
module controlador_display_7seg
  import pkg_display::*;
#(
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 50000,
  parameter int BLANK_CICLOS = 500,
  parameter bit MODO_HEX     = 1'b0,
  parameter bit ACTIVO_BAJO  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         habilitar,
  input  logic [4*N_DIGITOS-1:0]       digitos,
  input  logic [N_DIGITOS-1:0]         punto,
  input  logic                         supr_ceros,
  output logic [7:0]                   segmentos,
  output logic [N_DIGITOS-1:0]         anodos,
  output logic [$clog2(N_DIGITOS)-1:0] digito_actual,
  output logic                         fin_barrido
);

  localparam int IW = $clog2(N_DIGITOS);
  localparam int PW = $clog2(DIV_REFRESCO);
  localparam logic [PW-1:0] PRESC_MAX   = PW'(DIV_REFRESCO - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CICLOS);
  localparam logic [IW-1:0] IDX_MAX     = IW'(N_DIGITOS - 1);
  // Pin-level "off" pattern; XOR with it converts active-high to pin polarity.
  localparam logic [7:0]           SEG_INACT = {8{ACTIVO_BAJO}};
  localparam logic [N_DIGITOS-1:0] AN_INACT  = {N_DIGITOS{ACTIVO_BAJO}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] snap_q, snap_d;
  logic [N_DIGITOS-1:0]   snap_dp_q, snap_dp_d;
  logic                   fin_q;
  logic [7:0]             seg_q;
  logic [N_DIGITOS-1:0]   an_q;
  logic [IW-1:0]          dig_q;

  logic                 tick, wrap;
  logic [3:0]           nib_sel;
  logic                 dp_sel, lz_sel;
  logic [N_DIGITOS-1:0] an_sel, an_act;
  logic [6:0]           patron, glifo_act;

  assign tick = habilitar && (presc_q == PRESC_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    if (habilitar) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick)      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    if (wrap) begin
      snap_d    = digitos;
      snap_dp_d = punto;
    end
  end

  // Select the scanned digit. A digit is a leading zero when it and every
  // more significant nibble are zero; digit 0 is never suppressed.
  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    an_sel  = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_q == IW'(i)) begin
        nib_sel   = snap_q[4*i +: 4];
        dp_sel    = snap_dp_q[i];
        lz_sel    = supr_ceros && (i != 0) && ((snap_q >> (4*i)) == '0);
        an_sel[i] = 1'b1;
      end
    end
  end

  decodificador_glifo #(
    .MODO_HEX (MODO_HEX)
  ) u_glifo (
    .nibble_i (nib_sel),
    .patron_o (patron)
  );

  assign glifo_act = lz_sel ? GLIFO_BLANCO : patron;
  assign an_act    = (habilitar && (presc_q >= PRESC_BLANK)) ? an_sel : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      fin_q     <= 1'b0;
      seg_q     <= SEG_INACT;
      an_q      <= AN_INACT;
      dig_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      fin_q     <= wrap;
      seg_q     <= {dp_sel, glifo_act} ^ SEG_INACT;
      an_q      <= an_act ^ AN_INACT;
      dig_q     <= idx_q;
    end
  end

  assign segmentos     = seg_q;
  assign anodos        = an_q;
  assign digito_actual = dig_q;
  assign fin_barrido   = fin_q;

endmodule

// File: tb/tb_controlador_display_7seg.sv
// Scoreboard bench for controlador_display_7seg. Two instances share stimulus:
// dut_a is BCD / active-low, dut_b is hex / active-high. The reference model
// tracks the number of enabled cycles since reset and derives slot position,
// digit index and frame wrap from it with plain division and modulo.
module tb_controlador_display_7seg;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic [1:0]   dig;
    logic         fin;
  } salida_t;

  typedef struct packed {
    salida_t a;
    salida_t b;
  } esperado_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          habilitar;
  logic [4*N-1:0] digitos;
  logic [N-1:0]  punto;
  logic          supr_ceros;

  logic [7:0]    seg_a, seg_b;
  logic [N-1:0]  an_a, an_b;
  logic [1:0]    dig_a, dig_b;
  logic          fin_a, fin_b;

  int n_vec = 0;
  int n_err = 0;

  esperado_t cola[$];

  // Model state.
  int           e_cnt = 0;
  logic [15:0]  m_snap = '0;
  logic [3:0]   m_snap_dp = '0;
  logic [6:0]   tabla [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  controlador_display_7seg #(
    .N_DIGITOS(N), .DIV_REFRESCO(DIV), .BLANK_CICLOS(BLANK),
    .MODO_HEX(1'b0), .ACTIVO_BAJO(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar), .digitos(digitos),
    .punto(punto), .supr_ceros(supr_ceros), .segmentos(seg_a), .anodos(an_a),
    .digito_actual(dig_a), .fin_barrido(fin_a)
  );

  controlador_display_7seg #(
    .N_DIGITOS(N), .DIV_REFRESCO(DIV), .BLANK_CICLOS(BLANK),
    .MODO_HEX(1'b1), .ACTIVO_BAJO(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar), .digitos(digitos),
    .punto(punto), .supr_ceros(supr_ceros), .segmentos(seg_b), .anodos(an_b),
    .digito_actual(dig_b), .fin_barrido(fin_b)
  );

  function automatic salida_t en_reset(input bit ab);
    salida_t r;
    r.seg = ab ? 8'hFF : 8'h00;
    r.an  = ab ? '1 : '0;
    r.dig = '0;
    r.fin = 1'b0;
    return r;
  endfunction

  // Expected pins after an edge, given the enabled-cycle count before it.
  function automatic salida_t predecir(input bit hex, input bit ab, input int e_v,
                                       input logic hab, input logic [15:0] s,
                                       input logic [3:0] sdp, input logic supr);
    salida_t    r;
    int         p, idx;
    logic [3:0] nib;
    logic [6:0] g;
    p   = e_v % DIV;
    idx = (e_v / DIV) % N;
    nib = s[4*idx +: 4];
    g   = (nib > 4'd9 && !hex) ? 7'h00 : tabla[nib];
    if (supr && idx != 0 && (s >> (4*idx)) == 16'h0) g = 7'h00;
    r.seg = {sdp[idx], g};
    r.an  = (hab && p >= BLANK) ? (4'b0001 << idx) : 4'b0000;
    r.dig = 2'(idx);
    r.fin = hab && ((e_v + 1) % FRAME == 0);
    if (ab) begin
      r.seg = ~r.seg;
      r.an  = ~r.an;
    end
    return r;
  endfunction

  task automatic check(input string nombre, input salida_t act, input salida_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got seg=%h an=%b dig=%0d fin=%b, expected seg=%h an=%b dig=%0d fin=%b",
               nombre, $time, act.seg, act.an, act.dig, act.fin,
               exp.seg, exp.an, exp.dig, exp.fin);
    end
  endtask

  // Model: at each edge push the expected response, then advance.
  always @(posedge clk) begin
    esperado_t x;
    if (!reset_n) begin
      x.a = en_reset(1'b1);
      x.b = en_reset(1'b0);
      e_cnt     = 0;
      m_snap    = '0;
      m_snap_dp = '0;
    end else begin
      x.a = predecir(1'b0, 1'b1, e_cnt, habilitar, m_snap, m_snap_dp, supr_ceros);
      x.b = predecir(1'b1, 1'b0, e_cnt, habilitar, m_snap, m_snap_dp, supr_ceros);
      if (habilitar) begin
        if ((e_cnt + 1) % FRAME == 0) begin
          m_snap    = digitos;
          m_snap_dp = punto;
        end
        e_cnt = (e_cnt + 1) % FRAME;
      end
    end
    cola.push_back(x);
  end

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cola.size() > 0) begin
      esperado_t x;
      x = cola.pop_front();
      check("dut_a", {seg_a, an_a, dig_a, fin_a}, x.a);
      check("dut_b", {seg_b, an_b, dig_b, fin_b}, x.b);
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    habilitar  = 1'b0;
    digitos    = '0;
    punto      = '0;
    supr_ceros = 1'b0;

    ciclos(3);
    check("reset_a", {seg_a, an_a, dig_a, fin_a}, en_reset(1'b1));
    check("reset_b", {seg_b, an_b, dig_b, fin_b}, en_reset(1'b0));

    // Scan order, first frame shows the zero snapshot.
    reset_n   = 1'b1;
    habilitar = 1'b1;
    digitos   = 16'h4321;
    ciclos(3 * FRAME);

    // Snapshot coherence: change inputs mid-frame.
    digitos = 16'h1234;
    ciclos(FRAME + 6);
    digitos = 16'h5678;
    ciclos(2 * FRAME);

    // Leading-zero suppression.
    supr_ceros = 1'b1;
    digitos    = 16'h0070;
    ciclos(3 * FRAME);
    digitos    = 16'h0000;
    ciclos(2 * FRAME);

    // BCD vs hex glyph for code B, decimal point on digit 2.
    supr_ceros = 1'b0;
    digitos    = 16'h00B0;
    punto      = 4'b0100;
    ciclos(3 * FRAME);

    // Enable drop mid-slot.
    ciclos(6);
    habilitar = 1'b0;
    ciclos(10);
    habilitar = 1'b1;
    ciclos(FRAME);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) digitos    = 16'($urandom);
      if ($urandom_range(0, 7) == 0) punto      = 4'($urandom);
      if ($urandom_range(0, 15) == 0) supr_ceros = ~supr_ceros;
      habilitar = ($urandom_range(0, 7) != 0);
      ciclos(1);
    end

    // Asynchronous reset in the middle of a slot.
    habilitar = 1'b1;
    digitos   = 16'h9876;
    ciclos(2 * FRAME + 6);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_async_a", {seg_a, an_a, dig_a, fin_a}, en_reset(1'b1));
    check("reset_async_b", {seg_b, an_b, dig_b, fin_b}, en_reset(1'b0));
    ciclos(2);
    reset_n = 1'b1;
    ciclos(2 * FRAME);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
